// File: rtl/tx_fault_response_pkg.sv
// Shared XGMII character codes, link-fault codes, FSM encodings and fixed
// ordered-set words for the tx fault response stage.
package tx_fault_response_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  localparam logic [1:0] LINK_FAULT_OK     = 2'd0;
  localparam logic [1:0] LINK_FAULT_LOCAL  = 2'd1;
  localparam logic [1:0] LINK_FAULT_REMOTE = 2'd2;

  localparam logic [1:0] ST_NORMAL    = 2'd0;
  localparam logic [1:0] ST_SEND_RF   = 2'd1;
  localparam logic [1:0] ST_SEND_IDLE = 2'd2;

  localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};
  localparam logic [7:0]  IDLE_CTL  = 8'hFF;
  // Remote Fault sequence ordered set repeated in both 4-lane columns
  localparam logic [63:0] RF_WORD   = {2{8'h02, 8'h00, 8'h00, XGMII_SEQ}};
  localparam logic [7:0]  RF_CTL    = 8'h11;

  function automatic logic [2:0] lowest_lane(input logic [7:0] hits);
    logic [2:0] lane;
    casez (hits)
      8'b???????1: lane = 3'd0;
      8'b??????10: lane = 3'd1;
      8'b?????100: lane = 3'd2;
      8'b????1000: lane = 3'd3;
      8'b???10000: lane = 3'd4;
      8'b??100000: lane = 3'd5;
      8'b?1000000: lane = 3'd6;
      8'b10000000: lane = 3'd7;
      default:     lane = 3'd0;
    endcase
    return lane;
  endfunction

  function automatic logic [1:0] fault_state(input logic [1:0] target);
    logic [1:0] st;
    case (target)
      LINK_FAULT_LOCAL:  st = ST_SEND_RF;
      LINK_FAULT_REMOTE: st = ST_SEND_IDLE;
      default:           st = ST_NORMAL;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/tx_frame_tracker.sv
// START/TERM lane decode of the current tx word and the in_frame register;
// boundary is high when the current word does not sit inside a frame.
module tx_frame_tracker
  import tx_fault_response_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] txd,
  input  logic [7:0]  txc,
  output logic        boundary,
  output logic        start_q
);

  logic       in_frame_r;
  logic       in_frame_next_s;
  logic       start0_s;
  logic       start4_s;
  logic [7:0] term_hit_s;
  logic       term_any_s;
  logic [2:0] term_lane_s;
  logic [2:0] start_lane_s;

  // Character decode and next in_frame value
  always_comb begin
    start0_s = txc[0] && (txd[7:0] == XGMII_START);
    start4_s = txc[4] && (txd[39:32] == XGMII_START);
    for (int k = 0; k < 8; k++) begin
      term_hit_s[k] = txc[k] && (txd[8*k +: 8] == XGMII_TERM);
    end
    term_any_s   = |term_hit_s;
    term_lane_s  = lowest_lane(term_hit_s);
    start_lane_s = start4_s ? 3'd4 : 3'd0;
    start_q      = start0_s || start4_s;
    // A START after the TERM in the same word opens a new frame
    if (start_q && (!term_any_s || (start_lane_s > term_lane_s))) begin
      in_frame_next_s = 1'b1;
    end else if (term_any_s) begin
      in_frame_next_s = 1'b0;
    end else begin
      in_frame_next_s = in_frame_r;
    end
    boundary = !in_frame_r;
  end

  // in_frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_r <= 1'b0;
    end else begin
      in_frame_r <= in_frame_next_s;
    end
  end

endmodule

// File: rtl/tx_fault_response.sv
// Clause 46 tx reconciliation: replaces tx traffic with Remote Fault or idle
// while a fault is reported, switching in and out only at frame boundaries.
module tx_fault_response
  import tx_fault_response_pkg::*;
#(
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clk_xgmii_tx,
  input  logic        reset_xgmii_tx_n,
  input  logic        status_local_fault_ctx,
  input  logic        status_remote_fault_ctx,
  input  logic [63:0] txd_in,
  input  logic [7:0]  txc_in,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        fault_rsp_rf,
  output logic        fault_rsp_idle,
  output logic        frame_drop
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};

  logic              boundary_s;
  logic              start_q_s;
  logic [1:0]        target_s;
  logic [1:0]        state_r;
  logic [1:0]        next_state_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_next_s;
  logic [63:0]       txd_next_s;
  logic [7:0]        txc_next_s;
  logic              drop_next_s;

  tx_frame_tracker u_tracker (
    .clk      (clk_xgmii_tx),
    .rst_n    (reset_xgmii_tx_n),
    .txd      (txd_in),
    .txc      (txc_in),
    .boundary (boundary_s),
    .start_q  (start_q_s)
  );

  // Fault target and FSM next state / hold counter
  always_comb begin
    if (status_local_fault_ctx) begin
      target_s = LINK_FAULT_LOCAL;
    end else if (status_remote_fault_ctx) begin
      target_s = LINK_FAULT_REMOTE;
    end else begin
      target_s = LINK_FAULT_OK;
    end
    next_state_s = state_r;
    hold_next_s  = hold_cnt_r;
    case (state_r)
      ST_NORMAL: begin
        if ((target_s != LINK_FAULT_OK) && boundary_s) begin
          next_state_s = fault_state(target_s);
          hold_next_s  = HOLD_LOAD;
        end else begin
          next_state_s = ST_NORMAL;
          hold_next_s  = hold_cnt_r;
        end
      end
      ST_SEND_RF, ST_SEND_IDLE: begin
        if (target_s != LINK_FAULT_OK) begin
          next_state_s = fault_state(target_s);
          hold_next_s  = HOLD_LOAD;
        end else if ((hold_cnt_r == HOLD_ZERO) && boundary_s) begin
          next_state_s = ST_NORMAL;
          hold_next_s  = HOLD_ZERO;
        end else begin
          // Without a boundary the rest of the suppressed frame stays hidden
          next_state_s = state_r;
          hold_next_s  = (hold_cnt_r == HOLD_ZERO) ? HOLD_ZERO : hold_cnt_r - HOLD_W'(1);
        end
      end
      default: begin
        next_state_s = ST_NORMAL;
        hold_next_s  = HOLD_ZERO;
      end
    endcase
  end

  // Output word selection follows the state this word is handled in
  always_comb begin
    case (next_state_s)
      ST_NORMAL: begin
        txd_next_s = txd_in;
        txc_next_s = txc_in;
      end
      ST_SEND_RF: begin
        txd_next_s = RF_WORD;
        txc_next_s = RF_CTL;
      end
      ST_SEND_IDLE: begin
        txd_next_s = IDLE_WORD;
        txc_next_s = IDLE_CTL;
      end
      default: begin
        txd_next_s = IDLE_WORD;
        txc_next_s = IDLE_CTL;
      end
    endcase
    drop_next_s = start_q_s && (next_state_s != ST_NORMAL);
  end

  // State, hold counter and registered outputs
  always_ff @(posedge clk_xgmii_tx or negedge reset_xgmii_tx_n) begin
    if (!reset_xgmii_tx_n) begin
      state_r        <= ST_NORMAL;
      hold_cnt_r     <= HOLD_ZERO;
      xgmii_txd      <= IDLE_WORD;
      xgmii_txc      <= IDLE_CTL;
      fault_rsp_rf   <= 1'b0;
      fault_rsp_idle <= 1'b0;
      frame_drop     <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      hold_cnt_r     <= hold_next_s;
      xgmii_txd      <= txd_next_s;
      xgmii_txc      <= txc_next_s;
      fault_rsp_rf   <= (next_state_s == ST_SEND_RF);
      fault_rsp_idle <= (next_state_s == ST_SEND_IDLE);
      frame_drop     <= drop_next_s;
    end
  end

endmodule

// File: tb/tb_tx_fault_response.sv
// Directed bench for tx_fault_response: a vector table for single-cycle
// behaviour plus hand-written multi-cycle fault/hold/boundary sequences.
module tb_tx_fault_response;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] RF_W    = 64'h0200009C0200009C;
  localparam logic [7:0]  RF_C    = 8'h11;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [63:0] DATA_W  = 64'h0123456789ABCDEF;
  localparam logic [7:0]  DATA_C  = 8'h00;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [7:0]  TERM_C  = 8'hFF;
  localparam logic [63:0] TS_W    = 64'h555555FB07FDBBAA;
  localparam logic [7:0]  TS_C    = 8'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        loc;
  logic        rem;
  logic [63:0] txd_in;
  logic [7:0]  txc_in;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        fault_rsp_rf;
  logic        fault_rsp_idle;
  logic        frame_drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        l;
    logic        r;
    logic [63:0] d;
    logic [7:0]  c;
    logic [63:0] ed;
    logic [7:0]  ec;
    logic        erf;
    logic        eidle;
    logic        edrop;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  tx_fault_response #(.HOLD_CYCLES(64)) dut (
    .clk_xgmii_tx            (clk),
    .reset_xgmii_tx_n        (rst_n),
    .status_local_fault_ctx  (loc),
    .status_remote_fault_ctx (rem),
    .txd_in                  (txd_in),
    .txc_in                  (txc_in),
    .xgmii_txd               (xgmii_txd),
    .xgmii_txc               (xgmii_txc),
    .fault_rsp_rf            (fault_rsp_rf),
    .fault_rsp_idle          (fault_rsp_idle),
    .frame_drop              (frame_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [63:0] ed, input logic [7:0] ec,
                           input logic erf, input logic eidle, input logic edrop);
    chk({tag, "_txd"}, xgmii_txd, ed);
    chk({tag, "_txc"}, {56'd0, xgmii_txc}, {56'd0, ec});
    chk({tag, "_rf"}, {63'd0, fault_rsp_rf}, {63'd0, erf});
    chk({tag, "_idle"}, {63'd0, fault_rsp_idle}, {63'd0, eidle});
    chk({tag, "_drop"}, {63'd0, frame_drop}, {63'd0, edrop});
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic drive(input logic l, input logic r, input logic [63:0] d, input logic [7:0] c);
    loc    = l;
    rem    = r;
    txd_in = d;
    txc_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    loc = 1'b0; rem = 1'b0; txd_in = IDLE_W; txc_in = IDLE_C;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rf_cnt;
    int drop_cnt;
    int idle_cnt;

    tbl[0]  = '{1'b0, 1'b0, IDLE_W,  IDLE_C,  IDLE_W,  IDLE_C,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, START_W, START_C, START_W, START_C, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, DATA_W,  DATA_C,  DATA_W,  DATA_C,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, DATA_W,  DATA_C,  DATA_W,  DATA_C,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, TERM_W,  TERM_C,  TERM_W,  TERM_C,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, IDLE_W,  IDLE_C,  RF_W,    RF_C,    1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, IDLE_W,  IDLE_C,  RF_W,    RF_C,    1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, DATA_W,  DATA_C,  IDLE_W,  IDLE_C,  1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, START_W, START_C, RF_W,    RF_C,    1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, DATA_W,  DATA_C,  RF_W,    RF_C,    1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, DATA_W,  DATA_C,  RF_W,    RF_C,    1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    loc = 1'b1; rem = 1'b0; txd_in = DATA_W; txc_in = DATA_C;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", IDLE_W, IDLE_C, 1'b0, 1'b0, 1'b0);
    loc = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].l, tbl[i].r, tbl[i].d, tbl[i].c);
      check_out($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ec, tbl[i].erf, tbl[i].eidle, tbl[i].edrop);
    end

    // Reset mid-frame while in RF with local fault still asserted
    loc = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_out("midreset", IDLE_W, IDLE_C, 1'b0, 1'b0, 1'b0);

    // Local fault while idle, then exact 64-word hold after it drops
    do_reset();
    drive(1'b1, 1'b0, DATA_W, DATA_C);
    check_out("lf_enter", RF_W, RF_C, 1'b1, 1'b0, 1'b0);
    rf_cnt = 0;
    for (int w = 0; w < 200; w++) begin
      drive(1'b0, 1'b0, DATA_W, DATA_C);
      if (xgmii_txd == RF_W) rf_cnt++;
      else break;
    end
    chk("hold_len", 64'(rf_cnt), 64'd64);
    check_out("hold_exit", DATA_W, DATA_C, 1'b0, 1'b0, 1'b0);

    // Remote fault from the 3rd word of a 10-word frame
    do_reset();
    idle_cnt = 0;
    for (int w = 0; w < 10; w++) begin
      if (w == 0) drive(1'b0, 1'b0, START_W, START_C);
      else if (w == 9) drive(1'b0, w >= 2, TERM_W, TERM_C);
      else drive(1'b0, w >= 2, DATA_W, DATA_C);
      if ((w == 0 && xgmii_txd !== START_W) || (w == 9 && xgmii_txd !== TERM_W) ||
          (w > 0 && w < 9 && xgmii_txd !== DATA_W) || fault_rsp_idle) idle_cnt++;
    end
    chk("rem_frame_intact", 64'(idle_cnt), 64'd0);
    drive(1'b0, 1'b1, DATA_W, DATA_C);
    check_out("rem_after_term", IDLE_W, IDLE_C, 1'b0, 1'b1, 1'b0);

    // Fault on a START word, cleared while that frame is still running
    do_reset();
    drive(1'b1, 1'b0, START_W, START_C);
    check_out("drop_start", RF_W, RF_C, 1'b1, 1'b0, 1'b1);
    rf_cnt = 0;
    drop_cnt = 0;
    for (int w = 1; w <= 79; w++) begin
      if (w == 79) drive(1'b0, 1'b0, TERM_W, TERM_C);
      else drive(1'b0, 1'b0, DATA_W, DATA_C);
      if (xgmii_txd == RF_W && fault_rsp_rf) rf_cnt++;
      if (frame_drop) drop_cnt++;
    end
    chk("long_frame_rf", 64'(rf_cnt), 64'd79);
    chk("drop_pulse_len", 64'(drop_cnt), 64'd0);
    drive(1'b0, 1'b0, DATA_W, DATA_C);
    check_out("long_frame_exit", DATA_W, DATA_C, 1'b0, 1'b0, 1'b0);

    // TERM lane 2 + START lane 4 keeps in_frame high, so no switch there
    do_reset();
    drive(1'b0, 1'b0, START_W, START_C);
    drive(1'b0, 1'b0, DATA_W, DATA_C);
    drive(1'b0, 1'b1, TS_W, TS_C);
    check_out("ts_word", TS_W, TS_C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, DATA_W, DATA_C);
    check_out("ts_next", DATA_W, DATA_C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, TERM_W, TERM_C);
    check_out("ts_term", TERM_W, TERM_C, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, DATA_W, DATA_C);
    check_out("ts_switch", IDLE_W, IDLE_C, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
